layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Parametrised CNN layer sequencer: holds a run-time programmable per-layer config table and
//  steps the conv/pool/upsample datapath through NUM layers with a start_layer/done_layer
//  handshake. Replaces the fixed hard-coded layer table; adds abort, single-step, error flags.
// PARAMETERS
//  MAX_LAYER  16  table depth (max layers per run)
//  AW         22  OFM RAM address width
//  SIZE_W      9  ifm_size width
//  CH_W       11  ifm_channel / num_filter width
//  LW         $clog2(MAX_LAYER+1)  layer index/count width (derived)
//  CFG_W      SIZE_W+2*CH_W+7+2*AW  config word width (derived)
// PORTS
//  clk               in   1       clock
//  rst               in   1       synchronous active-high reset
//  start_cnn         in   1       run request, sampled in IDLE only
//  cfg_num_layer     in   LW      layers in this run, latched at accepted start_cnn
//  step_mode         in   1       1: pause after each layer until step_go
//  step_go           in   1       resume from PAUSE
//  abort             in   1       terminate run
//  done_layer        in   1       datapath layer-complete pulse
//  cfg_we            in   1       table write strobe
//  cfg_addr          in   LW      table entry index (0-based)
//  cfg_wdata         in   CFG_W   {ifm_size,ifm_channel,kernel_size[1:0],num_filter,maxpool_mode,
//                                  maxpool_stride[1:0],upsample_mode,start_write_addr,start_read_addr} MSB->LSB
//  start_layer       out  1       1-cycle pulse: layer config valid, datapath may start
//  done_cnn          out  1       1-cycle pulse: run complete
//  aborted           out  1       1-cycle pulse: run aborted
//  cfg_err           out  1       1-cycle pulse: illegal write/start rejected
//  busy              out  1       state != IDLE
//  count_layer       out  LW      1-based current layer, 0 when none issued
//  ifm_size..start_read_addr  out  field widths per cfg_wdata  registered layer config
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, index 0. Table contents not reset (retained).
//  - Table writes accepted only in IDLE; cfg_we when busy or cfg_addr>=MAX_LAYER: no write, cfg_err.
//  - States: IDLE, FETCH, ISSUE, RUN, PAUSE, DONE.
//  - IDLE: start_cnn & 1<=cfg_num_layer<=MAX_LAYER -> latch num, idx=0, FETCH.
//    start_cnn with num 0 or >MAX_LAYER -> cfg_err, stay IDLE.
//  - FETCH: config outputs <= table[idx], count_layer <= idx+1 -> ISSUE.
//  - ISSUE: start_layer high exactly this cycle -> RUN.
//  - RUN: wait done_layer. On done_layer: idx==num-1 -> DONE; else idx++, then
//    step_mode ? PAUSE : FETCH.
//  - PAUSE: step_go -> FETCH. DONE: done_cnn high this cycle -> IDLE.
//  - Latency: start_cnn sampled at edge N -> start_layer high N+2..N+3 (one cycle).
//    done_layer sampled at N -> next start_layer high after N+2; final done_cnn high after N+1.
//  - Config outputs hold until next FETCH; count_layer holds last value after DONE/abort.
//  - done_layer outside RUN ignored; start_cnn while busy ignored (no error).
//  - abort in any non-IDLE state -> IDLE next edge, aborted pulse, no done_cnn; abort wins
//    over simultaneous done_layer/step_go. abort in IDLE ignored.
//  - rst mid-run: immediate return to reset values on the edge; no pulses emitted.
// TESTING
//  - 3-layer run, table {318,3,3,16,...},{158,16,...},{78,...}; done_layer 10 cyc after each
//    start_layer -> 3 start_layer pulses, count_layer 1,2,3, fields match, done_cnn once.
//  - step_mode=1, 2 layers -> after 1st done_layer stays PAUSE (busy=1) until step_go,
//    then start_layer 2 cycles after step_go.
//  - abort same cycle as done_layer of layer 2/4 -> aborted pulse, busy=0, no done_cnn,
//    no further start_layer.
//  - cfg_we during RUN, and start_cnn with cfg_num_layer=0 -> cfg_err pulse each, table
//    unchanged, state unchanged.
//  - rst asserted in RUN -> all outputs 0 next cycle; new start_cnn re-runs layer 1 with
//    previously written table entries intact.
//  - MAX_LAYER=16 full run with done_layer 1 cycle after start_layer -> 16 layers, no drops.

Source files
------------

// File: rtl/layer_sequencer.sv
// CNN layer sequencer: run-time programmable per-layer config table, steps the datapath
// through a run with start_layer/done_layer handshakes, plus abort, single-step and error flags.
module layer_sequencer #(
  parameter int unsigned MAX_LAYER = 16,
  parameter int unsigned AW        = 22,
  parameter int unsigned SIZE_W    = 9,
  parameter int unsigned CH_W      = 11,
  parameter int unsigned LW        = $clog2(MAX_LAYER + 1),
  parameter int unsigned CFG_W     = SIZE_W + 2*CH_W + 7 + 2*AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_cnn,
  input  logic [LW-1:0]     cfg_num_layer,
  input  logic              step_mode,
  input  logic              step_go,
  input  logic              abort,
  input  logic              done_layer,
  input  logic              cfg_we,
  input  logic [LW-1:0]     cfg_addr,
  input  logic [CFG_W-1:0]  cfg_wdata,
  output logic              start_layer,
  output logic              done_cnn,
  output logic              aborted,
  output logic              cfg_err,
  output logic              busy,
  output logic [LW-1:0]     count_layer,
  output logic [SIZE_W-1:0] ifm_size,
  output logic [CH_W-1:0]   ifm_channel,
  output logic [1:0]        kernel_size,
  output logic [CH_W-1:0]   num_filter,
  output logic              maxpool_mode,
  output logic [1:0]        maxpool_stride,
  output logic              upsample_mode,
  output logic [AW-1:0]     start_write_addr,
  output logic [AW-1:0]     start_read_addr
);

  // Stored width of one layer entry; any bits of cfg_wdata above it are spare.
  localparam int unsigned TBL_W = SIZE_W + 2*CH_W + 6 + 2*AW;
  localparam int unsigned IW    = (MAX_LAYER > 1) ? $clog2(MAX_LAYER) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [IW-1:0]    idx;
  logic [LW-1:0]    num_q;
  logic [TBL_W-1:0] cfg_q;
  logic [TBL_W-1:0] tbl [MAX_LAYER];

  logic num_ok, start_ok, wr_ok, err_nxt, last_layer, halt;

  if (CFG_W > TBL_W) begin : g_spare
    logic [CFG_W-TBL_W-1:0] unused_spare;
    assign unused_spare = cfg_wdata[CFG_W-1:TBL_W];
  end

  assign {ifm_size, ifm_channel, kernel_size, num_filter, maxpool_mode,
          maxpool_stride, upsample_mode, start_write_addr, start_read_addr} = cfg_q;

  // Next-state and strobe decode; abort overrides every other transition.
  always_comb begin
    num_ok     = (cfg_num_layer != '0) && (cfg_num_layer <= LW'(MAX_LAYER));
    start_ok   = (state == S_IDLE) && start_cnn && num_ok;
    wr_ok      = cfg_we && (state == S_IDLE) && (cfg_addr < LW'(MAX_LAYER));
    err_nxt    = (cfg_we && !wr_ok) || ((state == S_IDLE) && start_cnn && !num_ok);
    last_layer = ((LW'(idx) + LW'(1)) == num_q);
    halt       = abort && (state != S_IDLE);
    state_nxt  = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_RUN;
      S_RUN: begin
        if (done_layer) begin
          if (last_layer)     state_nxt = S_DONE;
          else if (step_mode) state_nxt = S_PAUSE;
          else                state_nxt = S_FETCH;
        end
      end
      S_PAUSE: if (step_go) state_nxt = S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (halt) state_nxt = S_IDLE;
  end

  // Pulses trail the state that produces them by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      num_q       <= '0;
      cfg_q       <= '0;
      count_layer <= '0;
      start_layer <= 1'b0;
      done_cnn    <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != S_IDLE);
      start_layer <= (state == S_ISSUE) && !abort;
      done_cnn    <= (state == S_DONE) && !abort;
      aborted     <= halt;
      cfg_err     <= err_nxt;
      if (start_ok) begin
        num_q <= cfg_num_layer;
        idx   <= '0;
      end
      if ((state == S_FETCH) && !abort) begin
        cfg_q       <= tbl[idx];
        count_layer <= LW'(idx) + LW'(1);
      end
      if ((state == S_RUN) && done_layer && !abort && !last_layer)
        idx <= idx + IW'(1);
    end
  end

  // Table contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst)
      tbl[cfg_addr[IW-1:0]] <= cfg_wdata[TBL_W-1:0];
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: a timeline model predicts every output pulse and
// a negedge monitor checks them from per-pulse scoreboards.
module tb_layer_sequencer;
  localparam int unsigned MAX_LAYER = 16;
  localparam int unsigned AW        = 22;
  localparam int unsigned SIZE_W    = 9;
  localparam int unsigned CH_W      = 11;
  localparam int unsigned LW        = 5;
  localparam int unsigned CFG_W     = 82;
  localparam int unsigned TW        = 81;

  logic clk = 1'b0;
  logic rst, start_cnn, step_mode, step_go, abort, done_layer, cfg_we;
  logic [LW-1:0]     cfg_num_layer, cfg_addr;
  logic [CFG_W-1:0]  cfg_wdata;
  logic              start_layer, done_cnn, aborted, cfg_err, busy;
  logic [LW-1:0]     count_layer;
  logic [SIZE_W-1:0] ifm_size;
  logic [CH_W-1:0]   ifm_channel, num_filter;
  logic [1:0]        kernel_size, maxpool_stride;
  logic              maxpool_mode, upsample_mode;
  logic [AW-1:0]     start_write_addr, start_read_addr;

  layer_sequencer #(.MAX_LAYER(MAX_LAYER), .AW(AW), .SIZE_W(SIZE_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .start_cnn(start_cnn), .cfg_num_layer(cfg_num_layer),
    .step_mode(step_mode), .step_go(step_go), .abort(abort), .done_layer(done_layer),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start_layer(start_layer), .done_cnn(done_cnn), .aborted(aborted), .cfg_err(cfg_err),
    .busy(busy), .count_layer(count_layer), .ifm_size(ifm_size), .ifm_channel(ifm_channel),
    .kernel_size(kernel_size), .num_filter(num_filter), .maxpool_mode(maxpool_mode),
    .maxpool_stride(maxpool_stride), .upsample_mode(upsample_mode),
    .start_write_addr(start_write_addr), .start_read_addr(start_read_addr));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned    cyc;
    int unsigned    cnt;
    logic [TW-1:0]  cfg;
  } exp_t;

  exp_t          q_start[$];
  int unsigned   q_done[$], q_abort[$], q_err[$];
  logic [TW-1:0] ref_tbl [MAX_LAYER];
  int            n_cmp = 0;
  int            n_bad = 0;

  wire [TW-1:0] dut_cfg = {ifm_size, ifm_channel, kernel_size, num_filter, maxpool_mode,
                           maxpool_stride, upsample_mode, start_write_addr, start_read_addr};
  wire [90:0]   all_out = {start_layer, done_cnn, aborted, cfg_err, busy, count_layer, dut_cfg};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tick();
  endtask

  function automatic logic [CFG_W-1:0] pack(input int unsigned sz, ch, k, nf, mpm, mps, up,
                                            wa, ra, input bit spare);
    return {spare, SIZE_W'(sz), CH_W'(ch), 2'(k), CH_W'(nf), 1'(mpm), 2'(mps), 1'(up),
            AW'(wa), AW'(ra)};
  endfunction

  function automatic logic [CFG_W-1:0] rand_cfg();
    return pack($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, 1'($urandom));
  endfunction

  // Pulse monitor: each output pulse consumes the oldest expectation of its kind.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q_start.size() > 0 && q_start[0].cyc < cyc) begin
      chk("start_layer_missing", 128'(cyc), 128'(q_start[0].cyc));
      void'(q_start.pop_front());
    end
    if (q_done.size() > 0 && q_done[0] < cyc) begin
      chk("done_cnn_missing", 128'(cyc), 128'(q_done[0]));
      void'(q_done.pop_front());
    end
    if (q_abort.size() > 0 && q_abort[0] < cyc) begin
      chk("aborted_missing", 128'(cyc), 128'(q_abort[0]));
      void'(q_abort.pop_front());
    end
    if (q_err.size() > 0 && q_err[0] < cyc) begin
      chk("cfg_err_missing", 128'(cyc), 128'(q_err[0]));
      void'(q_err.pop_front());
    end
    if (start_layer) begin
      if (q_start.size() == 0) chk("start_layer_spurious", 128'(start_layer), 128'(0));
      else begin
        e = q_start.pop_front();
        chk("start_layer_cycle", 128'(cyc), 128'(e.cyc));
        chk("count_layer", 128'(count_layer), 128'(e.cnt));
        chk("layer_cfg", 128'(dut_cfg), 128'(e.cfg));
      end
    end
    if (done_cnn) begin
      if (q_done.size() == 0) chk("done_cnn_spurious", 128'(done_cnn), 128'(0));
      else chk("done_cnn_cycle", 128'(cyc), 128'(q_done.pop_front()));
    end
    if (aborted) begin
      if (q_abort.size() == 0) chk("aborted_spurious", 128'(aborted), 128'(0));
      else chk("aborted_cycle", 128'(cyc), 128'(q_abort.pop_front()));
    end
    if (cfg_err) begin
      if (q_err.size() == 0) chk("cfg_err_spurious", 128'(cfg_err), 128'(0));
      else chk("cfg_err_cycle", 128'(cyc), 128'(q_err.pop_front()));
    end
  end

  task automatic wr(input int unsigned a, input logic [CFG_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = LW'(a); cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    if (a < MAX_LAYER) ref_tbl[a] = d[TW-1:0];
    else q_err.push_back(cyc);
  endtask

  task automatic bad_start(input int unsigned num);
    start_cnn = 1'b1; cfg_num_layer = LW'(num);
    tick();
    start_cnn = 1'b0;
    q_err.push_back(cyc);
    chk("busy_after_bad_start", 128'(busy), 128'(0));
  endtask

  // Timeline model: start sampled at E -> start_layer at E+2; done_layer at D ->
  // next start_layer at D+2, done_cnn at D+1; step_go at G -> start_layer at G+2.
  task automatic do_run(input int unsigned num, input bit step, input int unsigned dlo,
                        input int unsigned dhi, input int unsigned abort_at, input bit poke);
    int unsigned s, d, g;
    exp_t e;
    start_cnn = 1'b1; cfg_num_layer = LW'(num); step_mode = step;
    tick();
    start_cnn = 1'b0;
    s = cyc + 2;
    for (int unsigned k = 0; k < num; k++) begin
      e.cyc = s; e.cnt = k + 1; e.cfg = ref_tbl[k];
      q_start.push_back(e);
      d = s + $urandom_range(dhi, dlo);
      if (poke && k == 0) begin
        wait_until(s + 2);
        cfg_we = 1'b1; cfg_addr = LW'(1); cfg_wdata = rand_cfg();
        tick();
        cfg_we = 1'b0;
        q_err.push_back(cyc);
        start_cnn = 1'b1; cfg_num_layer = LW'(3);
        tick();
        start_cnn = 1'b0;
      end
      wait_until(d - 1);
      done_layer = 1'b1;
      if (abort_at == k + 1) abort = 1'b1;
      tick();
      done_layer = 1'b0; abort = 1'b0;
      if (abort_at == k + 1) begin
        q_abort.push_back(cyc);
        repeat (12) tick();
        chk("busy_after_abort", 128'(busy), 128'(0));
        chk("count_after_abort", 128'(count_layer), 128'(abort_at));
        return;
      end
      if (k == num - 1) begin
        q_done.push_back(cyc + 1);
        wait_until(d + 2);
        chk("busy_after_done", 128'(busy), 128'(0));
        chk("count_after_done", 128'(count_layer), 128'(num));
      end else if (step) begin
        g = d + $urandom_range(6, 2);
        wait_until(g - 1);
        chk("busy_in_pause", 128'(busy), 128'(1));
        chk("count_in_pause", 128'(count_layer), 128'(k + 1));
        step_go = 1'b1;
        tick();
        step_go = 1'b0;
        s = cyc + 2;
      end else begin
        s = d + 2;
      end
    end
  endtask

  initial begin : drv
    int unsigned s;
    exp_t e;
    rst = 1'b1; start_cnn = 1'b0; step_mode = 1'b0; step_go = 1'b0; abort = 1'b0;
    done_layer = 1'b0; cfg_we = 1'b0; cfg_num_layer = '0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) tick();
    chk("reset_outputs", 128'(all_out), 128'(0));
    rst = 1'b0;
    tick();
    chk("idle_outputs", 128'(all_out), 128'(0));

    for (int unsigned i = 0; i < MAX_LAYER; i++) wr(i, rand_cfg());
    wr(0, pack(318, 3, 3, 16, 1, 2, 0, 22'h000000, 22'h100000, 1'b0));
    wr(1, pack(158, 16, 3, 32, 1, 2, 0, 22'h100000, 22'h000000, 1'b1));
    wr(2, pack(78, 32, 3, 64, 0, 1, 1, 22'h000000, 22'h100000, 1'b0));
    wr(16, rand_cfg());
    wr(31, rand_cfg());
    bad_start(0);
    bad_start(17);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("busy_after_idle_abort", 128'(busy), 128'(0));

    do_run(3, 1'b0, 10, 10, 0, 1'b0);
    do_run(2, 1'b1, 3, 8, 0, 1'b0);
    do_run(4, 1'b0, 3, 6, 2, 1'b0);
    do_run(3, 1'b0, 10, 10, 0, 1'b1);

    // Reset in the middle of layer 1, then rerun from the retained table.
    start_cnn = 1'b1; cfg_num_layer = LW'(2); step_mode = 1'b0;
    tick();
    start_cnn = 1'b0;
    s = cyc + 2;
    e.cyc = s; e.cnt = 1; e.cfg = ref_tbl[0];
    q_start.push_back(e);
    wait_until(s + 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("outputs_after_rst", 128'(all_out), 128'(0));
    tick();
    do_run(2, 1'b0, 2, 4, 0, 1'b0);

    for (int unsigned i = 0; i < MAX_LAYER; i++) wr(i, rand_cfg());
    do_run(MAX_LAYER, 1'b0, 1, 1, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      repeat (3) wr($urandom_range(MAX_LAYER - 1, 0), rand_cfg());
      do_run($urandom_range(MAX_LAYER, 1), 1'($urandom), 1, $urandom_range(8, 1),
             (r == 3) ? 1 : 0, 1'b0);
    end

    repeat (6) tick();
    chk("pending_start_layer", 128'(q_start.size()), 128'(0));
    chk("pending_done_cnn", 128'(q_done.size()), 128'(0));
    chk("pending_aborted", 128'(q_abort.size()), 128'(0));
    chk("pending_cfg_err", 128'(q_err.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: bench still running at cycle %0d, limit 40000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
